data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the data cache's block-fill/write-back interface. It accepts single-block read and write requests from the cache controller, holds the requester in `mem_busywait` for a fixed multi-cycle access latency, then performs the access against an internal block array and releases the requester. It sits between the data cache and the backing store and replaces the untimed behavioural memory in the CPU system bench.

## Interface
- `ADDR_W`, 6, block address width; array depth is 2**ADDR_W blocks.
- `DATA_W`, 32, block width in bits (4 bytes).
- `LATENCY`, 5, access cycles per request; legal range 2..255.

- `CLK` in 1, system clock, rising edge active.
- `RESET` in 1, asynchronous, active-low reset.
- `mem_read` in 1, block read request, held by the cache until released.
- `mem_write` in 1, block write request, held by the cache until released.
- `mem_address` in ADDR_W, block address, stable while a request is held.
- `mem_writedata` in DATA_W, write block, stable while `mem_write` is held.
- `mem_readdata` out DATA_W, registered read block.
- `mem_busywait` out 1, stall to the cache.

## Operation
- States: IDLE, ACCESS, DONE (plus WPOST, see Configuration).
- IDLE:
  - `mem_busywait` = `mem_read | mem_write`, combinational, so the cache stalls in the same cycle it asks.
  - On an edge with a request present, latch op, address and data, load the counter with LATENCY-1, and go to ACCESS.
- ACCESS:
  - `mem_busywait` = 1. The counter decrements each edge.
  - On the edge where the counter is 0, perform the access and go to DONE. A read loads `mem_readdata` from the array. A write stores the latched data to the array.
- DONE:
  - `mem_busywait` = 0 for exactly one cycle. The cache drops its request on the edge that ends DONE.
  - Requests present during DONE are ignored. Go to IDLE.
- `mem_read` and `mem_write` both high in IDLE: treated as a write. `mem_readdata` is unchanged.
- Address is used modulo 2**ADDR_W. There is no wrap logic beyond the natural width; 6'h3F and 6'h00 are independent blocks.
- `mem_readdata` holds its value until the next completed read. Writes never change it.

## Timing
- Request cycle is cycle 0. Busywait is high in cycles 0..LATENCY. DONE is cycle LATENCY+1. Read data is valid from cycle LATENCY+1.
- Total occupancy per request is LATENCY+2 cycles, including DONE and the return to IDLE.
- Reset (RESET=0), at any time:
  - State goes to IDLE, the counter clears, and any latched request is discarded.
  - `mem_readdata` = 0 and every array block = 0.
  - `mem_busywait` follows `mem_read | mem_write`.
  - No partial write ever reaches the array.
- Release of reset is synchronous to the first rising edge with RESET=1.

## Configuration
- `DMEM_POSTED_WRITE_EN` defined:
  - A write in IDLE does not raise `mem_busywait`. It is latched at the edge, and the responder enters WPOST for LATENCY cycles, then commits the write and returns to IDLE. There is no DONE for posted writes.
  - During WPOST, `mem_busywait` = `mem_read | mem_write`, and new requests wait.
  - A read queued behind a posted write starts its own full LATENCY after the commit and returns the committed data.
  - A read+write collision is still a write.
- `DMEM_POSTED_WRITE_EN` undefined: WPOST does not exist, and all requests follow IDLE/ACCESS/DONE.

## Structure
- Package `dmem_pkg` holds:
  - the state enum (IDLE, ACCESS, DONE, WPOST);
  - the `DMEM_LAT_DEFAULT` = 5 constant;
  - the counter width constant (8 bits).
- Sub-module `dmem_array` is the block storage. It has a synchronous write port, a read port, and async active-low clear. The FSM, counter and request latch live in `data_mem_responder`.

## Test plan
- Release reset, then read addr 6'h00 → busywait high for cycles 0..5, low in cycle 6, `mem_readdata` = 32'h00000000.
- Write 6'h0A with 32'hDEADBEEF, then read 6'h0A → busywait high for 6 cycles per access, `mem_readdata` = 32'hDEADBEEF. A following write to 6'h0B leaves `mem_readdata` at 32'hDEADBEEF.
- Read and write high together at 6'h03 with data 32'h12345678 → `mem_readdata` unchanged; a later read of 6'h03 returns 32'h12345678.
- Write 6'h3F with 32'hA5A5A5A5, with RESET low in cycle 3 of ACCESS → state IDLE, `mem_readdata` = 0; a later read of 6'h3F returns 32'h00000000.
- Write 6'h3F with 32'h11111111 and 6'h00 with 32'h22222222, then read both → 32'h11111111 and 32'h22222222.
- `DMEM_POSTED_WRITE_EN` defined:
  - Write 6'h05 with 32'hCAFEF00D → busywait stays low.
  - An immediate read of 6'h05 → busywait high until the commit plus its own access (at least 2×LATENCY cycles), then `mem_readdata` = 32'hCAFEF00D.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its block array.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    WPOST  = 2'd3
  } dmem_state_e;

  localparam int DMEM_LAT_DEFAULT = 5;
  localparam int DMEM_CNT_W       = 8;

endpackage

// File: rtl/dmem_array.sv
// Block storage: one synchronous write port, one combinational read port,
// every block cleared by the asynchronous active-low reset.
module dmem_array #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage update; reset clears every block so no partial write survives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end else begin
      mem_q[waddr_i] <= mem_q[waddr_i];
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency block memory responder for the data cache fill/write-back port.
// Optional posted writes are enabled with `define DMEM_POSTED_WRITE_EN.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int LATENCY = DMEM_LAT_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_writedata,
  output logic [DATA_W-1:0] mem_readdata,
  output logic              mem_busywait
);

  localparam logic [DMEM_CNT_W-1:0] LAT_M1 = DMEM_CNT_W'(LATENCY - 1);

  dmem_state_e           state_q;
  logic [DMEM_CNT_W-1:0] cnt_q;
  logic                  op_wr_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [DATA_W-1:0]     arr_rdata_s;
  logic                  we_s;
  logic                  busy_s;
  logic                  cnt_zero_s;

  assign cnt_zero_s = (cnt_q == {DMEM_CNT_W{1'b0}});

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .we_i    (we_s),
    .waddr_i (addr_q),
    .wdata_i (wdata_q),
    .raddr_i (addr_q),
    .rdata_o (arr_rdata_s)
  );

  // Stall and array write strobe derived from the current state.
  always_comb begin
    busy_s = 1'b0;
    we_s   = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef DMEM_POSTED_WRITE_EN
        busy_s = mem_read & ~mem_write;
`else
        busy_s = mem_read | mem_write;
`endif
      end
      ACCESS: begin
        busy_s = 1'b1;
        we_s   = op_wr_q & cnt_zero_s;
      end
      DONE: begin
        busy_s = 1'b0;
      end
      WPOST: begin
        busy_s = mem_read | mem_write;
        we_s   = cnt_zero_s;
      end
      default: begin
        busy_s = 1'b0;
        we_s   = 1'b0;
      end
    endcase
  end

  // Request FSM, latency counter, request latch and read-data register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_read || mem_write) begin
            op_wr_q <= mem_write;
            addr_q  <= mem_address;
            wdata_q <= mem_writedata;
            cnt_q   <= LAT_M1;
`ifdef DMEM_POSTED_WRITE_EN
            state_q <= mem_write ? WPOST : ACCESS;
`else
            state_q <= ACCESS;
`endif
          end
        end
        ACCESS: begin
          if (cnt_zero_s) begin
            if (!op_wr_q) begin
              rdata_q <= arr_rdata_s;
            end
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        WPOST: begin
          if (cnt_zero_s) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_readdata = rdata_q;
  assign mem_busywait = busy_s;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a block-level model.
module tb_data_mem_responder;

  localparam int LAT = 5;
`ifdef DMEM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        CLK;
  logic        RESET;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  logic [31:0] model_mem [64];
  logic [31:0] model_rd;
  int          post_left;
  int          n_checks;
  int          n_errors;

  data_mem_responder #(.ADDR_W(6), .DATA_W(32), .LATENCY(LAT)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
    model_rd  = 32'h0;
    post_left = 0;
  endtask

  // One cache-style transaction: hold the request while stalled, drop it after DONE.
  task automatic xact(input string tag, input logic rd, input logic wr,
                      input logic [5:0] a, input logic [31:0] d);
    int busy;
    int exp_busy;
    bit posted_wr;
    posted_wr = wr && POSTED;
    exp_busy  = post_left + (posted_wr ? 0 : LAT + 1);
    @(negedge CLK);
    mem_read = rd; mem_write = wr; mem_address = a; mem_writedata = d;
    #1;
    busy = 0;
    while (mem_busywait && busy < 200) begin
      busy++;
      @(negedge CLK);
      #1;
    end
    if (wr) model_mem[a] = d;
    else    model_rd = model_mem[a];
    check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    check({tag, "_rdata"}, mem_readdata, model_rd);
    @(posedge CLK);
    #1;
    mem_read = 1'b0; mem_write = 1'b0;
    post_left = posted_wr ? LAT : 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    post_left = (post_left > n) ? post_left - n : 0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    RESET = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_address = 6'h00; mem_writedata = 32'h0;
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_rdata", mem_readdata, 32'h0);
    check("rst_busy_idle", 32'(mem_busywait), 32'h0);
    mem_read = 1'b1;
    #1;
    check("rst_busy_req", 32'(mem_busywait), 32'h1);
    @(negedge CLK);
    mem_read = 1'b0;
    RESET = 1'b1;

    xact("rd00", 1'b1, 1'b0, 6'h00, 32'h0);
    xact("wr0A", 1'b0, 1'b1, 6'h0A, 32'hDEADBEEF);
    idle(LAT + 1);
    xact("rd0A", 1'b1, 1'b0, 6'h0A, 32'h0);
    xact("wr0B", 1'b0, 1'b1, 6'h0B, 32'h0BADF00D);
    idle(LAT + 1);
    xact("rw03", 1'b1, 1'b1, 6'h03, 32'h12345678);
    idle(LAT + 1);
    xact("rd03", 1'b1, 1'b0, 6'h03, 32'h0);
    xact("wr05", 1'b0, 1'b1, 6'h05, 32'hCAFEF00D);
    xact("rd05", 1'b1, 1'b0, 6'h05, 32'h0);

    // Reset in the middle of a write access to 6'h3F.
    @(negedge CLK);
    mem_write = 1'b1; mem_read = 1'b0;
    mem_address = 6'h3F; mem_writedata = 32'hA5A5A5A5;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    #1;
    check("midrst_rdata", mem_readdata, 32'h0);
    check("midrst_busy", 32'(mem_busywait), POSTED ? 32'h0 : 32'h1);
    @(negedge CLK);
    mem_write = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    model_clear();
    xact("rd3F_cleared", 1'b1, 1'b0, 6'h3F, 32'h0);
    xact("rd0A_cleared", 1'b1, 1'b0, 6'h0A, 32'h0);

    xact("wr3F", 1'b0, 1'b1, 6'h3F, 32'h11111111);
    xact("wr00", 1'b0, 1'b1, 6'h00, 32'h22222222);
    xact("rd3F", 1'b1, 1'b0, 6'h3F, 32'h0);
    xact("rd00b", 1'b1, 1'b0, 6'h00, 32'h0);

    for (int i = 0; i < 40; i++) begin
      logic [5:0]  a;
      logic [31:0] d;
      int          op;
      a  = ($urandom_range(0, 5) == 0) ? 6'h3F : {3'b000, 3'($urandom_range(0, 7))};
      d  = $urandom;
      op = $urandom_range(0, 2);
      xact("rand", (op != 1), (op != 0), a, d);
      idle($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
